// File: rtl/bus_master_ctrl_if.sv
// Core-request / arbitrated-bus signal bundle for bus_master_ctrl.
// Signals ending in '_' are active-low bus handshakes.
interface bus_master_ctrl_if;
  // Core request / response side.
  logic        req_valid;
  logic        req_rw;
  logic [29:0] req_addr;
  logic [31:0] req_wr_data;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rd_data;
  logic        rsp_err;
  logic        busy;

  // Arbitrated bus side.
  logic        bus_req_;
  logic        bus_grnt_;
  logic [29:0] bus_addr;
  logic        bus_as_;
  logic        bus_rw;
  logic [31:0] bus_wr_data;
  logic [31:0] bus_rd_data;
  logic        bus_rdy_;

  // The controller itself.
  modport master (
    input  req_valid, req_rw, req_addr, req_wr_data,
    output req_ready, rsp_valid, rsp_rd_data, rsp_err, busy,
    output bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data,
    input  bus_grnt_, bus_rd_data, bus_rdy_
  );

  // Core, arbiter and slave environment around the controller.
  modport slave (
    output req_valid, req_rw, req_addr, req_wr_data,
    input  req_ready, rsp_valid, rsp_rd_data, rsp_err, busy,
    input  bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data,
    output bus_grnt_, bus_rd_data, bus_rdy_
  );
endinterface

// File: rtl/bus_master_ctrl.sv
// bus_master_ctrl: single-outstanding bus master. Accepts one core request,
// arbitrates for the bus, performs one address-strobe access and returns a
// one-cycle response pulse.
// Optional timeout on a stalled slave: define BUS_MASTER_TIMEOUT_EN.
module bus_master_ctrl (
  input logic               clk,
  input logic               reset,
  bus_master_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StReq    = 2'd1,
    StAccess = 2'd2,
    StWait   = 2'd3
  } state_e;

  state_e      state_q;
  logic        bus_req_q;
  logic        bus_as_q;
  logic        bus_rw_q;
  logic [29:0] bus_addr_q;
  logic [31:0] bus_wr_data_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rd_data_q;
  logic        done;
  logic        timed_out;

`ifdef BUS_MASTER_TIMEOUT_EN
  logic [7:0]  tmo_cnt_q;
  logic        rsp_err_q;
`endif

  // Completion conditions: slave ready in ACCESS/WAIT, or WAIT stalled too long.
  always_comb begin
    done      = 1'b0;
    timed_out = 1'b0;
    if ((state_q == StAccess || state_q == StWait) && !bus.bus_rdy_) begin
      done = 1'b1;
    end
`ifdef BUS_MASTER_TIMEOUT_EN
    // Counter holds 254 during the 255th stalled WAIT cycle; it would reach 255 at this edge.
    if (state_q == StWait && bus.bus_rdy_ && tmo_cnt_q == 8'd254) begin
      timed_out = 1'b1;
    end
`endif
  end

  // Main FSM with all bus and response outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      bus_req_q     <= 1'b1;
      bus_as_q      <= 1'b1;
      bus_rw_q      <= 1'b1;
      bus_addr_q    <= '0;
      bus_wr_data_q <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rd_data_q <= '0;
`ifdef BUS_MASTER_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      rsp_err_q     <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      if (done || timed_out) begin
        state_q       <= StIdle;
        bus_req_q     <= 1'b1;
        bus_as_q      <= 1'b1;
        rsp_valid_q   <= 1'b1;
        // Writes and timed-out accesses return zero data.
        rsp_rd_data_q <= (done && bus_rw_q) ? bus.bus_rd_data : 32'h0;
`ifdef BUS_MASTER_TIMEOUT_EN
        rsp_err_q     <= timed_out;
`endif
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus.req_valid) begin
              bus_rw_q      <= bus.req_rw;
              bus_addr_q    <= bus.req_addr;
              bus_wr_data_q <= bus.req_wr_data;
              bus_req_q     <= 1'b0;
              state_q       <= StReq;
            end
          end
          StReq: begin
            if (!bus.bus_grnt_) begin
              bus_as_q  <= 1'b0;
              state_q   <= StAccess;
`ifdef BUS_MASTER_TIMEOUT_EN
              tmo_cnt_q <= '0;
`endif
            end
          end
          StAccess: begin
            // Address strobe lasts exactly one cycle.
            bus_as_q <= 1'b1;
            state_q  <= StWait;
          end
          StWait: begin
`ifdef BUS_MASTER_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
`endif
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.req_ready   = (state_q == StIdle);
  assign bus.busy        = (state_q != StIdle);
  assign bus.bus_req_    = bus_req_q;
  assign bus.bus_as_     = bus_as_q;
  assign bus.bus_rw      = bus_rw_q;
  assign bus.bus_addr    = bus_addr_q;
  assign bus.bus_wr_data = bus_wr_data_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rd_data = rsp_rd_data_q;
`ifdef BUS_MASTER_TIMEOUT_EN
  assign bus.rsp_err     = rsp_err_q;
`else
  assign bus.rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_bus_master_ctrl.sv
// Scoreboard bench for bus_master_ctrl: directed transactions push expected
// responses; a negedge monitor pops and compares on every rsp_valid.
module tb_bus_master_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bus_master_ctrl_if bif ();

  bus_master_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } rsp_t;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  rsp_t exp_q[$];
  int   rsp_times[$];
  int   rsp_cnt = 0;

  logic [29:0] exp_addr;
  logic [31:0] exp_wdata;
  logic        exp_rw;
  int          as_low = 0;
  bit          stab_bad = 1'b0;
  int          hi_run = 0;
  int          last_gap = 0;

  // Slave / arbiter behaviour knobs.
  int          grant_delay = 0;
  int          wait_cycles = 0;
  bit          noisy = 1'b0;
  logic [31:0] rd_base = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Arbiter + slave model, driven on the falling edge from observed bus phase.
  initial begin
    int gcnt;
    int wcnt;
    bit seen_as;
    gcnt = 0;
    wcnt = 0;
    seen_as = 1'b0;
    bif.bus_grnt_ = 1'b1;
    bif.bus_rdy_ = 1'b1;
    bif.bus_rd_data = 32'h0;
    forever begin
      @(negedge clk);
      bif.bus_rd_data = rd_base ^ {2'b00, bif.bus_addr};
      if (reset || bif.bus_req_) begin
        gcnt = 0;
        wcnt = 0;
        seen_as = 1'b0;
        bif.bus_grnt_ = 1'b1;
        bif.bus_rdy_ = 1'b1;
      end else if (!bif.bus_as_) begin
        seen_as = 1'b1;
        wcnt = 0;
        bif.bus_grnt_ = 1'b1;
        bif.bus_rdy_ = (wait_cycles == 0) ? 1'b0 : 1'b1;
      end else if (seen_as) begin
        wcnt++;
        bif.bus_rdy_ = (wcnt >= wait_cycles) ? 1'b0 : 1'b1;
        bif.bus_grnt_ = noisy ? 1'b0 : 1'b1;
      end else begin
        bif.bus_grnt_ = (gcnt >= grant_delay) ? 1'b0 : 1'b1;
        bif.bus_rdy_ = noisy ? 1'b0 : 1'b1;
        gcnt++;
      end
    end
  end

  // Response monitor and scoreboard.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        as_low = 0;
        stab_bad = 1'b0;
      end else begin
        if (!bif.bus_as_) as_low++;
        if (bif.busy && (bif.bus_addr !== exp_addr || bif.bus_wr_data !== exp_wdata ||
                         bif.bus_rw !== exp_rw)) begin
          stab_bad = 1'b1;
        end
        if (bif.bus_req_) begin
          hi_run++;
        end else begin
          if (hi_run > 0) last_gap = hi_run;
          hi_run = 0;
        end
        if (bif.rsp_valid) begin
          rsp_cnt++;
          rsp_times.push_back(cyc);
          if (exp_q.size() == 0) begin
            chk("rsp_valid_unexpected", {31'b0, bif.rsp_valid}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_rd_data", bif.rsp_rd_data, e.rd);
            chk("rsp_err", {31'b0, bif.rsp_err}, {31'b0, e.err});
            chk("bus_as_low_cycles", as_low, 32'd1);
            chk("bus_fields_stable", {31'b0, stab_bad}, 32'd0);
          end
          as_low = 0;
          stab_bad = 1'b0;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a request (caller sits #1 after an edge); returns #1 after the accept edge.
  task automatic issue(input logic rw, input logic [29:0] addr, input logic [31:0] data,
                       input bit hold, output int acc_cyc);
    int t;
    bit ok;
    t = 0;
    bif.req_valid = 1'b1;
    bif.req_rw = rw;
    bif.req_addr = addr;
    bif.req_wr_data = data;
    ok = bif.req_ready;
    while (!ok && t < 200) begin
      @(posedge clk);
      #1;
      ok = bif.req_ready;
      t++;
    end
    chk("req_accept", {31'b0, ok}, 32'd1);
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    exp_addr = addr;
    exp_wdata = data;
    exp_rw = rw;
    if (!hold) bif.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target, input int budget);
    int t;
    t = 0;
    while (rsp_cnt < target && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("rsp_arrived", rsp_cnt, target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1;
    int a2;
    bif.req_valid = 1'b0;
    bif.req_rw = 1'b0;
    bif.req_addr = '0;
    bif.req_wr_data = '0;

    // Reset state.
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'b0, bif.req_ready}, 32'd1);
    chk("rst_busy", {31'b0, bif.busy}, 32'd0);
    chk("rst_bus_req_", {31'b0, bif.bus_req_}, 32'd1);
    chk("rst_bus_as_", {31'b0, bif.bus_as_}, 32'd1);
    chk("rst_bus_rw", {31'b0, bif.bus_rw}, 32'd1);
    chk("rst_bus_addr", {2'b0, bif.bus_addr}, 32'd0);
    chk("rst_bus_wr_data", bif.bus_wr_data, 32'd0);
    chk("rst_rsp_valid", {31'b0, bif.rsp_valid}, 32'd0);
    chk("rst_rsp_rd_data", bif.rsp_rd_data, 32'd0);
    chk("rst_rsp_err", {31'b0, bif.rsp_err}, 32'd0);
    reset = 1'b0;
    idle(2);

    // Read, immediate grant, zero-wait slave.
    grant_delay = 0;
    wait_cycles = 0;
    noisy = 1'b0;
    rd_base = 32'hDEADBEEF;
    exp_q.push_back({32'hDEADBEEF, 1'b0});
    issue(1'b1, 30'h0, 32'h0, 1'b0, a1);
    wait_rsp(1, 50);
    chk("read_latency", rsp_times[0] - a1, 32'd3);
    idle(3);
    chk("rsp_rd_data_hold", bif.rsp_rd_data, 32'hDEADBEEF);
    chk("rsp_valid_single_pulse", {31'b0, bif.rsp_valid}, 32'd0);

    // Write, grant after 4 extra REQ cycles, two WAIT cycles, noisy rdy/grant.
    grant_delay = 4;
    wait_cycles = 2;
    noisy = 1'b1;
    rd_base = 32'hCAFEF00D;
    exp_q.push_back({32'h0, 1'b0});
    issue(1'b0, 30'h0000100, 32'h12345678, 1'b0, a1);
    wait_rsp(2, 50);
    chk("write_latency", rsp_times[1] - a1, 32'd9);

    // Back-to-back reads with req_valid held.
    grant_delay = 0;
    wait_cycles = 0;
    noisy = 1'b0;
    rd_base = 32'h50000000;
    exp_q.push_back({32'h50000003, 1'b0});
    exp_q.push_back({32'h50000007, 1'b0});
    issue(1'b1, 30'h3, 32'h0, 1'b1, a1);
    issue(1'b1, 30'h7, 32'h0, 1'b0, a2);
    wait_rsp(4, 50);
    chk("b2b_accept_in_rsp_cycle", a2, rsp_times[2]);
    chk("b2b_bus_req_gap", last_gap, 32'd1);
    chk("b2b_second_latency", rsp_times[3] - a2, 32'd3);

    // Request pulsed while REQ is pending must be ignored.
    grant_delay = 5;
    exp_q.push_back({32'h0, 1'b0});
    issue(1'b0, 30'h2A, 32'hA5A5A5A5, 1'b0, a1);
    idle(1);
    chk("req_ready_in_req", {31'b0, bif.req_ready}, 32'd0);
    bif.req_valid = 1'b1;
    bif.req_rw = 1'b1;
    bif.req_addr = 30'h3FF;
    idle(1);
    bif.req_valid = 1'b0;
    wait_rsp(5, 50);
    idle(10);
    chk("ignored_req_single_rsp", rsp_cnt, 32'd5);
    chk("ignored_req_idle", {31'b0, bif.busy}, 32'd0);

    // Reset asserted while in WAIT aborts the access.
    grant_delay = 0;
    wait_cycles = 1000000;
    issue(1'b1, 30'h5, 32'h0, 1'b0, a1);
    idle(4);
    chk("in_wait_busy", {31'b0, bif.busy}, 32'd1);
    chk("in_wait_bus_req_", {31'b0, bif.bus_req_}, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_bus_req_", {31'b0, bif.bus_req_}, 32'd1);
    chk("abort_bus_as_", {31'b0, bif.bus_as_}, 32'd1);
    chk("abort_req_ready", {31'b0, bif.req_ready}, 32'd1);
    chk("abort_rsp_valid", {31'b0, bif.rsp_valid}, 32'd0);
    idle(5);
    chk("abort_no_rsp", rsp_cnt, 32'd5);

    // Slave never ready.
`ifdef BUS_MASTER_TIMEOUT_EN
    exp_q.push_back({32'h0, 1'b1});
    issue(1'b1, 30'h9, 32'h0, 1'b0, a1);
    wait_rsp(6, 400);
    chk("timeout_latency", rsp_times[5] - a1, 32'd258);
    chk("timeout_bus_req_", {31'b0, bif.bus_req_}, 32'd1);
`else
    issue(1'b1, 30'h9, 32'h0, 1'b0, a1);
    idle(1000);
    chk("stall_busy", {31'b0, bif.busy}, 32'd1);
    chk("stall_bus_req_", {31'b0, bif.bus_req_}, 32'd0);
    chk("stall_bus_as_", {31'b0, bif.bus_as_}, 32'd1);
    chk("stall_no_rsp", rsp_cnt, 32'd5);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);
`endif

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
